// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types for the decode-stage forwarding/hazard controller: operand-select
// codes, the per-stage shadow control record and the match rule used by every stage.
package fwd_hazard_ctrl_pkg;

    localparam int REG_AW_DFLT = 5;
    localparam int ZR_REG_IDX  = 31;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_sel_t;

    typedef struct packed {
        logic [REG_AW_DFLT-1:0] rd;
        logic                   regwrite;
        logic                   memtoreg;
    } stage_ctl_t;

    // A stage can feed a source only if it writes a real register equal to that source.
    function automatic logic stage_hit(
        input stage_ctl_t             stage,
        input logic [REG_AW_DFLT-1:0] src,
        input logic                   use_src,
        input logic [REG_AW_DFLT-1:0] zr
    );
        return use_src & stage.regwrite & (stage.rd == src) & (src != zr);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_sel.sv
// Combinational operand-select priority encoder for one source register:
// the youngest matching stage (E, then M, then W) supplies the operand.
module fwd_sel
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int ZR_REG = ZR_REG_IDX
) (
    input  logic [REG_AW_DFLT-1:0] src,
    input  logic                   use_src,
    input  stage_ctl_t             stage_e,
    input  stage_ctl_t             stage_m,
    input  stage_ctl_t             stage_w,
    output fwd_sel_t               sel
);

    localparam logic [REG_AW_DFLT-1:0] ZR = REG_AW_DFLT'(ZR_REG);

    logic hit_e;
    logic hit_m;
    logic hit_w;

    assign hit_e = stage_hit(stage_e, src, use_src, ZR);
    assign hit_m = stage_hit(stage_m, src, use_src, ZR);
    assign hit_w = stage_hit(stage_w, src, use_src, ZR);

    always_comb begin
        sel = FWD_RF;
        if (hit_e) begin
            sel = FWD_EX;
        end else if (hit_m) begin
            sel = FWD_MEM;
        end else if (hit_w) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Decode-stage forwarding and load-use hazard controller with an E/M/W shadow pipeline.
// Optional performance counters are built when FWD_HAZARD_PERF_EN is defined.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DFLT,
    parameter int ZR_REG = ZR_REG_IDX,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rn,
    input  logic [REG_AW-1:0] dec_rm,
    input  logic              dec_use_rn,
    input  logic              dec_use_rm,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_regwrite,
    input  logic              dec_memtoreg,
    input  logic              flush,
    output logic [1:0]        fwdr1,
    output logic [1:0]        fwdr2,
    output logic              stall,
    output logic              bubble
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_fwd_cnt
`endif
);

    stage_ctl_t e_q;
    stage_ctl_t m_q;
    stage_ctl_t w_q;
    logic       e_valid_q;

    fwd_sel_t   rn_sel;
    fwd_sel_t   ab_sel;
    logic       ld_use;

    fwd_sel #(.ZR_REG(ZR_REG)) u_fwd_rn (
        .src     (dec_rn),
        .use_src (dec_use_rn),
        .stage_e (e_q),
        .stage_m (m_q),
        .stage_w (w_q),
        .sel     (rn_sel)
    );

    fwd_sel #(.ZR_REG(ZR_REG)) u_fwd_ab (
        .src     (dec_rm),
        .use_src (dec_use_rm),
        .stage_e (e_q),
        .stage_m (m_q),
        .stage_w (w_q),
        .sel     (ab_sel)
    );

    assign fwdr1 = rn_sel;
    assign fwdr2 = ab_sel;

    // An EX-forward code already encodes "E writes this used, non-zero source",
    // so a load in E plus either EX code is exactly the load-use condition.
    assign ld_use = dec_valid & ~flush & e_valid_q & e_q.memtoreg
                  & ((rn_sel == FWD_EX) | (ab_sel == FWD_EX));

    assign stall  = ld_use;
    assign bubble = flush | ld_use;

    // Shadow pipeline advance: decode -> E -> M -> W
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q       <= '0;
            m_q       <= '0;
            w_q       <= '0;
            e_valid_q <= 1'b0;
        end else begin
            w_q <= m_q;
            m_q <= e_q;
            if (bubble) begin
                e_q       <= '0;
                e_valid_q <= 1'b0;
            end else begin
                e_q       <= '{rd:       dec_rd,
                               regwrite: dec_valid & dec_regwrite,
                               memtoreg: dec_valid & dec_memtoreg};
                e_valid_q <= dec_valid;
            end
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    logic [1:0] fwd_inc;

    assign fwd_inc = {1'b0, (fwdr1 != 2'b00)} + {1'b0, (fwdr2 != 2'b00)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else begin
            if (stall) begin
                perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
            end
            if (!stall && dec_valid) begin
                perf_fwd_cnt <= perf_fwd_cnt + CNT_W'(fwd_inc);
            end
        end
    end
`else
    // Counter width only matters when the counters exist.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: an instruction-history model predicts the
// outputs every cycle, and literal expectations pin the key scenarios.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       dec_valid;
    logic [4:0] dec_rn;
    logic [4:0] dec_rm;
    logic       dec_use_rn;
    logic       dec_use_rm;
    logic [4:0] dec_rd;
    logic       dec_regwrite;
    logic       dec_memtoreg;
    logic       flush;
    logic [1:0] fwdr1;
    logic [1:0] fwdr2;
    logic       stall;
    logic       bubble;

    int tests = 0;
    int fails = 0;

    // Model: the last three instructions that entered EX, youngest first.
    logic [4:0] h_rd [3];
    logic       h_wr [3];
    logic       h_ld [3];

    fwd_hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .dec_valid    (dec_valid),
        .dec_rn       (dec_rn),
        .dec_rm       (dec_rm),
        .dec_use_rn   (dec_use_rn),
        .dec_use_rm   (dec_use_rm),
        .dec_rd       (dec_rd),
        .dec_regwrite (dec_regwrite),
        .dec_memtoreg (dec_memtoreg),
        .flush        (flush),
        .fwdr1        (fwdr1),
        .fwdr2        (fwdr2),
        .stall        (stall),
        .bubble       (bubble)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] m_fwd(input logic [4:0] src, input logic use_s);
        logic [1:0] code;
        code = 2'b00;
        if (use_s && src != 5'd31) begin
            for (int i = 2; i >= 0; i--) begin
                if (h_wr[i] && h_rd[i] == src) code = 2'(i + 1);
            end
        end
        return code;
    endfunction

    function automatic logic m_stall();
        logic dep;
        dep = (dec_use_rn && dec_rn == h_rd[0] && dec_rn != 5'd31)
           || (dec_use_rm && dec_rm == h_rd[0] && dec_rm != 5'd31);
        return dec_valid && !flush && h_ld[0] && h_wr[0] && dep;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                h_rd[i] <= 5'd0;
                h_wr[i] <= 1'b0;
                h_ld[i] <= 1'b0;
            end
        end else begin
            for (int i = 2; i > 0; i--) begin
                h_rd[i] <= h_rd[i-1];
                h_wr[i] <= h_wr[i-1];
                h_ld[i] <= h_ld[i-1];
            end
            if (flush || m_stall()) begin
                h_rd[0] <= 5'd0;
                h_wr[0] <= 1'b0;
                h_ld[0] <= 1'b0;
            end else begin
                h_rd[0] <= dec_rd;
                h_wr[0] <= dec_valid && dec_regwrite;
                h_ld[0] <= dec_valid && dec_memtoreg;
            end
        end
    end

    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic compare_model(input string tag);
        logic st;
        st = m_stall();
        chk({tag, ".stall"}, {1'b0, stall}, {1'b0, st});
        chk({tag, ".bubble"}, {1'b0, bubble}, {1'b0, flush || st});
        if (!st) begin
            chk({tag, ".fwdr1"}, fwdr1, m_fwd(dec_rn, dec_use_rn));
            chk({tag, ".fwdr2"}, fwdr2, m_fwd(dec_rm, dec_use_rm));
        end
    endtask

    task automatic expect4(input string tag, input logic [1:0] f1, input logic [1:0] f2,
                           input logic st, input logic bb);
        chk({tag, ".lit_fwdr1"}, fwdr1, f1);
        chk({tag, ".lit_fwdr2"}, fwdr2, f2);
        chk({tag, ".lit_stall"}, {1'b0, stall}, {1'b0, st});
        chk({tag, ".lit_bubble"}, {1'b0, bubble}, {1'b0, bb});
    endtask

    task automatic expect_sb(input string tag, input logic st, input logic bb);
        chk({tag, ".lit_stall"}, {1'b0, stall}, {1'b0, st});
        chk({tag, ".lit_bubble"}, {1'b0, bubble}, {1'b0, bb});
    endtask

    // One decode cycle: drive after the edge, then check model before the falling edge.
    task automatic cyc(input string tag, input logic v,
                       input logic [4:0] rn, input logic urn,
                       input logic [4:0] rm, input logic urm,
                       input logic [4:0] rd, input logic rw, input logic ld,
                       input logic fl);
        @(posedge clk);
        #1;
        dec_valid    = v;
        dec_rn       = rn;
        dec_use_rn   = urn;
        dec_rm       = rm;
        dec_use_rm   = urm;
        dec_rd       = rd;
        dec_regwrite = rw;
        dec_memtoreg = ld;
        flush        = fl;
        #2;
        compare_model(tag);
    endtask

    task automatic nop();
        cyc("nop", 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset        = 1'b1;
        dec_valid    = 1'b0;
        dec_rn       = 5'd0;
        dec_rm       = 5'd0;
        dec_use_rn   = 1'b0;
        dec_use_rm   = 1'b0;
        dec_rd       = 5'd0;
        dec_regwrite = 1'b0;
        dec_memtoreg = 1'b0;
        flush        = 1'b0;
        #2;
        expect4("reset", 2'b00, 2'b00, 1'b0, 1'b0);
        compare_model("reset");
        @(negedge clk);
        reset = 1'b0;

        // ADDI X1 ; ADD X2,X1,X3
        cyc("addi_x1", 1, 5'd2, 1, 5'd0, 0, 5'd1, 1, 0, 0);
        expect4("addi_x1", 2'b00, 2'b00, 1'b0, 1'b0);
        cyc("add_x2", 1, 5'd1, 1, 5'd3, 1, 5'd2, 1, 0, 0);
        expect4("fwd_ex", 2'b01, 2'b00, 1'b0, 1'b0);

        // ADD X5 ; NOP ; SUB X6,X7,X5
        cyc("add_x5a", 1, 5'd9, 1, 5'd10, 1, 5'd5, 1, 0, 0);
        nop();
        cyc("sub_mem", 1, 5'd7, 1, 5'd5, 1, 5'd6, 1, 0, 0);
        expect4("fwd_mem", 2'b00, 2'b10, 1'b0, 1'b0);

        // ADD X5 ; NOP ; NOP ; SUB X6,X7,X5
        cyc("add_x5b", 1, 5'd9, 1, 5'd10, 1, 5'd5, 1, 0, 0);
        nop();
        nop();
        cyc("sub_wb", 1, 5'd7, 1, 5'd5, 1, 5'd6, 1, 0, 0);
        expect4("fwd_wb", 2'b00, 2'b11, 1'b0, 1'b0);

        // LDUR X4 ; ADD X8,X4,X4 -> one stall cycle, then MEM forward
        cyc("ldur_x4a", 1, 5'd20, 1, 5'd0, 0, 5'd4, 1, 1, 0);
        cyc("ld_use", 1, 5'd4, 1, 5'd4, 1, 5'd8, 1, 0, 0);
        expect_sb("ld_use", 1'b1, 1'b1);
        cyc("ld_use_rel", 1, 5'd4, 1, 5'd4, 1, 5'd8, 1, 0, 0);
        expect4("ld_use_rel", 2'b10, 2'b10, 1'b0, 1'b0);

        // Load writing X31, consumer of X31: no forward, no stall
        cyc("ldur_x31", 1, 5'd21, 1, 5'd0, 0, 5'd31, 1, 1, 0);
        cyc("read_x31", 1, 5'd31, 1, 5'd31, 1, 5'd9, 1, 0, 0);
        expect4("zero_reg", 2'b00, 2'b00, 1'b0, 1'b0);

        // Flush beats load-use; flushed slot must not forward
        cyc("ldur_x4b", 1, 5'd20, 1, 5'd0, 0, 5'd4, 1, 1, 0);
        cyc("flush", 1, 5'd4, 1, 5'd4, 1, 5'd8, 1, 0, 1);
        expect_sb("flush", 1'b0, 1'b1);
        cyc("post_flush", 1, 5'd4, 1, 5'd8, 1, 5'd11, 1, 0, 0);
        expect4("post_flush", 2'b10, 2'b00, 1'b0, 1'b0);

        // Invalid decode slot never writes, never stalls
        cyc("inv_wr_x7", 0, 5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0);
        cyc("read_x7", 1, 5'd7, 1, 5'd0, 0, 5'd12, 1, 0, 0);
        expect4("invalid_wr", 2'b00, 2'b00, 1'b0, 1'b0);
        cyc("ldur_x4c", 1, 5'd20, 1, 5'd0, 0, 5'd4, 1, 1, 0);
        cyc("inv_use", 0, 5'd4, 1, 5'd4, 1, 5'd8, 1, 0, 0);
        expect_sb("inv_use", 1'b0, 1'b0);

        // X2 produced in both E and M: E wins
        cyc("add_x2a", 1, 5'd0, 1, 5'd0, 0, 5'd2, 1, 0, 0);
        cyc("add_x2b", 1, 5'd12, 1, 5'd0, 0, 5'd2, 1, 0, 0);
        cyc("read_x2", 1, 5'd2, 1, 5'd2, 1, 5'd13, 1, 0, 0);
        expect4("youngest", 2'b01, 2'b01, 1'b0, 1'b0);

        // Reset during a load-use stall drops it immediately
        cyc("ldur_x4d", 1, 5'd20, 1, 5'd0, 0, 5'd4, 1, 1, 0);
        cyc("ld_use2", 1, 5'd4, 1, 5'd4, 1, 5'd8, 1, 0, 0);
        expect_sb("ld_use2", 1'b1, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        expect4("reset_mid", 2'b00, 2'b00, 1'b0, 1'b0);
        compare_model("reset_mid");
        @(negedge clk);
        reset = 1'b0;
        cyc("after_reset", 1, 5'd4, 1, 5'd4, 1, 5'd8, 1, 0, 0);
        expect4("after_reset", 2'b00, 2'b00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control-side counterpart of the 5-stage datapath's decode-stage operand forwarding interface.
- Consumes the decode-stage instruction's source and destination fields and its write controls.
- Keeps its own shadow pipeline of destination-register state for the EX, MEM and WB stages.
- Drives the fwdr1/fwdr2 operand-select codes, a load-use stall, and an EX-bubble indication back to the datapath and the fetch logic.

Parameters:
- REG_AW, 5, register address width.
- ZR_REG, 31, zero register index; never forwarded, never stalled on.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- dec_valid  in  1  decode stage holds a real instruction.
- dec_rn  in  REG_AW  first source register (Rn).
- dec_rm  in  REG_AW  second source register, post Reg2Loc select (Ab).
- dec_use_rn  in  1  instruction reads Rn.
- dec_use_rm  in  1  instruction reads Ab.
- dec_rd  in  REG_AW  destination register.
- dec_regwrite  in  1  instruction writes the register file.
- dec_memtoreg  in  1  instruction is a load.
- flush  in  1  taken branch; squash the decode-stage instruction.
- fwdr1  out  2  Rn operand select: 00 regfile, 01 EX result, 10 MEM Dw, 11 WB Dw_r.
- fwdr2  out  2  Ab operand select, same encoding.
- stall  out  1  hold PC and the fetch/decode register this cycle.
- bubble  out  1  EX stage receives a bubble at the next edge.

Behaviour:
- Shadow stages E, M, W. Each holds rd, regwrite and memtoreg; E additionally holds valid.
- Stage advance on every rising clk edge:
  - W <= M; M <= E.
  - E <= decode fields, gated as follows. If bubble is high, E loads regwrite=0, memtoreg=0, valid=0 and rd=0. Otherwise E loads the decode fields, with regwrite effective = dec_valid & dec_regwrite.
- Reset (asynchronous): clears all stage regwrite, memtoreg, valid and rd to 0. Outputs are combinational, so after reset fwdr1=fwdr2=00, stall=0 and bubble=0, provided flush is low.
- Stage match condition for source register s (the same rule applies independently to Rn and Ab): the stage has regwrite=1, stage rd == s, and s != ZR_REG. A source with its use bit low always gives code 00.
- Forward priority, evaluated combinationally in the same cycle:
  - E match gives 01.
  - Otherwise an M match gives 10.
  - Otherwise a W match gives 11.
  - Otherwise 00.
  - The youngest producer always wins.
- Load-use hazard:
  - Condition: dec_valid & ~flush & E.memtoreg & E.regwrite & (Rn or Ab, with its use bit set, matches E.rd with rd != ZR_REG).
  - Action: stall=1 and bubble=1. fwdr codes are still driven but are don't-care, because the datapath captures a value that is discarded.
  - Next cycle the load is in M, so the dependent source resolves to 10. The stall lasts exactly 1 cycle.
- Flush: bubble=1 and stall=0. The decode instruction becomes a bubble in E. Flush has priority over the load-use stall.
- bubble = flush | stall.
- When dec_valid=0 the E entry is non-writing, whatever dec_regwrite is.
- Reset asserted mid-stall clears E, so stall drops combinationally.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- Defined: adds outputs perf_stall_cnt[CNT_W] and perf_fwd_cnt[CNT_W].
  - perf_stall_cnt increments each cycle stall=1.
  - perf_fwd_cnt increments by the number of nonzero fwdr codes in cycles with stall=0 and dec_valid=1 (0, 1 or 2).
  - Both counters wrap modulo 2^CNT_W and are cleared by reset.
- Undefined: ports and logic are absent. Forwarding and hazard behaviour is identical in both builds.

Decomposition:
- Shared package:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10, FWD_WB=2'b11.
  - ZR_REG constant.
  - stage_ctl_t struct {rd, regwrite, memtoreg}.
- Sub-module fwd_sel: purely combinational priority selector (src, use, E/M/W stage_ctl_t → fwd_sel_t), instantiated twice, once for Rn and once for Ab.
- Top level holds the shadow registers, the hazard logic and the optional counters.

Test Plan:
- ADDI X1 then ADD X2,X1,X3 → second instruction sees fwdr1=01, fwdr2=00, stall=0.
- ADD X5 at t, NOP, then SUB X6,X7,X5 → fwdr2=10. With two NOPs between them → fwdr2=11.
- LDUR X4 then ADD X8,X4,X4 → stall=1 and bubble=1 for exactly 1 cycle. The following cycle gives fwdr1=fwdr2=10 with stall=0.
- Producer writes X31 (regwrite=1), consumer reads X31 → fwdr=00, and no stall even when the producer is a load.
- LDUR X4 in E, dependent ADD in decode, flush=1 → stall=0, bubble=1, and E is non-writing next cycle.
- X2 written in E and in M simultaneously, consumer reads X2 → 01, so E wins. Assert reset during a load-use stall → stall=0 immediately and fwdr codes return to 00.
